// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding-window generator for a raster pixel stream: two line delays feed
// a two-stage pipeline that presents the window two cycles after acceptance.
module matrix_3x3_gen #(
  parameter int IMG_HDISP  = 640,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_vsync,
  input  logic                  in_href,
  input  logic                  in_clken,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vsync,
  output logic                  out_href,
  output logic                  out_clken,
  output logic [DATA_WIDTH-1:0] p11,
  output logic [DATA_WIDTH-1:0] p12,
  output logic [DATA_WIDTH-1:0] p13,
  output logic [DATA_WIDTH-1:0] p21,
  output logic [DATA_WIDTH-1:0] p22,
  output logic [DATA_WIDTH-1:0] p23,
  output logic [DATA_WIDTH-1:0] p31,
  output logic [DATA_WIDTH-1:0] p32,
  output logic [DATA_WIDTH-1:0] p33,
  output logic                  out_edge
);

  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(IMG_HDISP - 1);
  localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

  // Stream semantics: no back-pressure. A pixel is taken on a rising edge of
  // clock exactly when in_href and in_clken are both high; nothing else
  // moves the line delays, counters or window.
  logic accept;
  logic vsync_d, href_d;
  logic vsync_rise, href_fall;

  assign accept     = in_href & in_clken;
  assign vsync_rise = in_vsync & ~vsync_d;
  assign href_fall  = href_d & ~in_href;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= in_vsync;
      href_d  <= in_href;
    end
  end

  // A frame start seen together with a pixel forces that pixel to address 0.
  logic [AW-1:0] ptr, ptr_eff, ptr_next;
  assign ptr_eff = vsync_rise ? '0 : ptr;

  always_comb begin
    ptr_next = ptr_eff;
    if (accept) begin
      ptr_next = (ptr_eff == PTR_LAST) ? '0 : ptr_eff + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_next;
  end

  // Line memories keep their contents across reset and frames; stale rows are
  // reported through out_edge instead of being cleared.
  logic [DATA_WIDTH-1:0] line1_mem [IMG_HDISP];
  logic [DATA_WIDTH-1:0] line2_mem [IMG_HDISP];
  logic [DATA_WIDTH-1:0] tap1, tap2;

  assign tap1 = line1_mem[ptr_eff];
  assign tap2 = line2_mem[ptr_eff];

  always_ff @(posedge clock) begin
    if (accept) begin
      line1_mem[ptr_eff] <= in_data;
      line2_mem[ptr_eff] <= tap1;
    end
  end

  logic [15:0] col_cnt, row_cnt, row_eff;
  logic        edge_now;

  assign row_eff  = vsync_rise ? 16'd0 : row_cnt;
  assign edge_now = (row_eff < 16'd2) || (col_cnt < 16'd2);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (href_fall)
        col_cnt <= '0;
      else if (accept && col_cnt != CNT_MAX)
        col_cnt <= col_cnt + 16'd1;

      if (vsync_rise)
        row_cnt <= '0;
      else if (href_fall && row_cnt != CNT_MAX)
        row_cnt <= row_cnt + 16'd1;
    end
  end

  // Stage 1: capture the three row taps and the per-pixel flags.
  logic [DATA_WIDTH-1:0] s1_row1, s1_row2, s1_row3;
  logic                  s1_accept, s1_edge;
  logic                  s1_vsync, s1_href, s1_clken;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_row1   <= '0;
      s1_row2   <= '0;
      s1_row3   <= '0;
      s1_accept <= 1'b0;
      s1_edge   <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_href   <= 1'b0;
      s1_clken  <= 1'b0;
    end else begin
      s1_row1   <= tap2;
      s1_row2   <= tap1;
      s1_row3   <= in_data;
      s1_accept <= accept;
      s1_edge   <= edge_now;
      s1_vsync  <= in_vsync;
      s1_href   <= in_href;
      s1_clken  <= in_clken;
    end
  end

  // Stage 2: shift the window on accepted pixels only; hold otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
      out_edge  <= 1'b0;
      out_vsync <= 1'b0;
      out_href  <= 1'b0;
      out_clken <= 1'b0;
    end else begin
      if (s1_accept) begin
        p11 <= p12; p12 <= p13; p13 <= s1_row1;
        p21 <= p22; p22 <= p23; p23 <= s1_row2;
        p31 <= p32; p32 <= p33; p33 <= s1_row3;
        out_edge <= s1_edge;
      end
      out_vsync <= s1_vsync;
      out_href  <= s1_href;
      out_clken <= s1_clken;
    end
  end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Randomised and directed bench for matrix_3x3_gen against a history-based
// window model.
module tb_matrix_3x3_gen;

  localparam int H  = 4;
  localparam int DW = 8;
  localparam int EW = 90;

  logic          clock, rst_n;
  logic          in_vsync, in_href, in_clken;
  logic [DW-1:0] in_data;
  logic          out_vsync, out_href, out_clken, out_edge;
  logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  matrix_3x3_gen #(.IMG_HDISP(H), .DATA_WIDTH(DW)) dut (
    .clock(clock), .rst_n(rst_n),
    .in_vsync(in_vsync), .in_href(in_href), .in_clken(in_clken), .in_data(in_data),
    .out_vsync(out_vsync), .out_href(out_href), .out_clken(out_clken),
    .p11(p11), .p12(p12), .p13(p13), .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33), .out_edge(out_edge)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: accepted-pixel history plus frame/line counters
  logic [DW-1:0]  hist[$];
  logic [EW-1:0]  exp_q[$];
  int             base, frm_cnt, row_m, col_m;
  bit             prev_vs, prev_hr;
  bit             vs1, vs2, hr1, hr2, ck1, ck2;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      base = hist.size();
      frm_cnt = 0; row_m = 0; col_m = 0;
      prev_vs = 0; prev_hr = 0;
      vs1 = 0; vs2 = 0; hr1 = 0; hr2 = 0; ck1 = 0; ck2 = 0;
    end else begin
      bit rise, fall;
      rise = in_vsync && !prev_vs;
      fall = prev_hr && !in_href;
      if (rise) begin
        // an incomplete last line leaves the line delays misaligned with this frame
        if (frm_cnt % H != 0) base = hist.size();
        frm_cnt = 0;
        row_m = 0;
      end else if (fall && row_m < 65535) begin
        row_m++;
      end
      if (fall) col_m = 0;
      if (in_href && in_clken) begin
        int k;
        logic [71:0] win;
        logic edg, chk;
        hist.push_back(in_data);
        k = hist.size() - 1;
        edg = (row_m < 2) || (col_m < 2);
        chk = (k - 2*H - 2 >= base);
        win = '0;
        if (chk)
          win = {hist[k-2*H-2], hist[k-2*H-1], hist[k-2*H],
                 hist[k-H-2],   hist[k-H-1],   hist[k-H],
                 hist[k-2],     hist[k-1],     hist[k]};
        exp_q.push_back({16'(frm_cnt), chk, edg, win});
        frm_cnt++;
        if (col_m < 65535) col_m++;
      end
      vs2 = vs1; vs1 = in_vsync;
      hr2 = hr1; hr1 = in_href;
      ck2 = ck1; ck1 = in_clken;
      prev_vs = in_vsync;
      prev_hr = in_href;
    end
  end

  // scoreboard: compare away from the rising edge
  bit          directed = 0;
  bit          snap_seen = 0;
  logic [72:0] snap;
  logic [71:0] last_win = '0;

  always @(negedge clock) begin
    logic [71:0] win;
    win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
    if (rst_n) begin
      check("out_vsync", 96'(out_vsync), 96'(vs2));
      check("out_href",  96'(out_href),  96'(hr2));
      check("out_clken", 96'(out_clken), 96'(ck2));
      if (out_clken && out_href) begin
        if (exp_q.size() == 0) begin
          check("spurious_pixel", 96'(1), 96'(0));
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("out_edge", 96'(out_edge), 96'(e[72]));
          if (e[73]) check("window", 96'(win), 96'(e[71:0]));
          if (directed && e[89:74] == 16'd10) begin
            snap = {win, out_edge};
            snap_seen = 1;
          end
        end
      end else if (out_clken) begin
        check("window_hold", 96'(win), 96'(last_win));
      end
    end
    last_win = win;
  end

  // driver tasks
  task automatic drive(input bit vs, input bit hr, input bit ck, input logic [DW-1:0] d);
    @(negedge clock);
    in_vsync = vs; in_href = hr; in_clken = ck; in_data = d;
  endtask

  task automatic vsync_pulse();
    drive(1, 0, 0, '0); drive(1, 0, 0, '0);
    drive(0, 0, 0, '0); drive(0, 0, 0, '0);
  endtask

  task automatic line(input int start, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) while ($urandom_range(1) == 0) drive(0, 1, 0, DW'($urandom_range(255)));
      drive(0, 1, 1, rnd ? DW'($urandom_range(255)) : DW'(start + i));
    end
    drive(0, 0, 0, '0);
    drive(0, 0, 1, DW'($urandom_range(255)));
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
  endtask

  task automatic directed_frame();
    directed = 1;
    snap_seen = 0;
    vsync_pulse();
    for (int l = 0; l < 3; l++) line(1 + 4*l, 4, 0);
    repeat (4) drive(0, 0, 0, '0);
    directed = 0;
    check("pix11_seen", 96'(snap_seen), 96'(1));
    check("pix11_window", 96'(snap),
          96'({8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 1'b0}));
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    rst_n = 0;
    in_vsync = 0; in_href = 0; in_clken = 0; in_data = '0;
    #1;
    check("reset_outputs",
          96'({p11, p12, p13, p21, p22, p23, p31, p32, p33, out_edge, out_vsync, out_href, out_clken}),
          96'(0));
    @(negedge clock);
    #2;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    in_vsync = 0; in_href = 0; in_clken = 0; in_data = '0;
    repeat (3) @(negedge clock);
    do_reset();

    directed_frame();

    // over-long line wraps the pointers, then a normal line follows
    vsync_pulse();
    line(20, 6, 0);
    line(40, 4, 0);
    repeat (4) drive(0, 0, 0, '0);

    // reset in the middle of a line, then a clean frame
    vsync_pulse();
    drive(0, 1, 1, 8'd50);
    drive(0, 1, 1, 8'd51);
    do_reset();
    directed_frame();

    // random data with random strobe gaps
    repeat (3) begin
      vsync_pulse();
      for (int l = 0; l < 4; l++) line(0, H, 1);
    end

    repeat (10) drive(0, 0, 0, '0);
    check("drain", 96'(exp_q.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
